// File: rtl/pdm_capture_pkg.sv
// Shared constants and FSM encoding for the PDM capture packer.
// Imported by the interface, the per-channel packer and the top.
package pdm_capture_pkg;

    localparam int WORD_BITS = 32;
    localparam int BIT_CNT_W = $clog2(WORD_BITS);
    localparam logic [3:0] BYTE_EN_ALL = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/pdm_capture_packer_if.sv
// BRAM port-B write bus shared by all microphone channels.
// The packer drives it as master; the memory side observes it as slave.
interface pdm_capture_packer_if #(
    parameter int NUM_MICS   = 8,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   addrb;
    logic [3:0]              web;
    logic [32*NUM_MICS-1:0]  dinb;

    modport master (
        output addrb,
        output web,
        output dinb
    );

    modport slave (
        input addrb,
        input web,
        input dinb
    );
endinterface

// File: rtl/pdm_bit_packer.sv
// One channel's 32-bit PDM shift register; word_next is the word as it
// would look after shifting in the current bit, so the top can latch it.
module pdm_bit_packer
    import pdm_capture_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 shift_en,
    input  logic                 bit_in,
    output logic [WORD_BITS-1:0] word_next
);

    logic [WORD_BITS-1:0] shift_q;
    logic [WORD_BITS-1:0] shift_d;

    assign word_next = {shift_q[WORD_BITS-2:0], bit_in};

    always_comb begin
        shift_d = shift_q;
        if (clr) begin
            shift_d = '0;
        end else if (shift_en) begin
            shift_d = word_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/pdm_capture_packer.sv
// Packs NUM_MICS parallel PDM bit streams into 32-bit words and writes them
// to a shared BRAM port, one word per channel per strobe, until the buffer fills.
module pdm_capture_packer
    import pdm_capture_pkg::*;
#(
    parameter int NUM_MICS    = 8,
    parameter int COUNT_WIDTH = 14,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arm,
    input  logic [NUM_MICS-1:0]    mic_data,
    input  logic                   mic_data_valid,
    pdm_capture_packer_if.master   bram,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH:0]   words_written
);

    localparam int DATA_W = WORD_BITS * NUM_MICS;

    state_e                  state_q, state_d;
    logic                    arm_q, arm_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [COUNT_WIDTH-1:0]  word_idx_q, word_idx_d;
    logic [COUNT_WIDTH:0]    words_written_q, words_written_d;
    logic [ADDR_WIDTH-1:0]   addrb_q, addrb_d;
    logic [3:0]              web_q, web_d;
    logic [DATA_W-1:0]       dinb_q, dinb_d;

    logic                    shift_en;
    logic                    clr;
    logic                    arm_rise;
    logic [DATA_W-1:0]       packed_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MICS; gi++) begin : g_ch
            pdm_bit_packer u_packer (
                .clk       (clk),
                .rst       (rst),
                .clr       (clr),
                .shift_en  (shift_en),
                .bit_in    (mic_data[gi]),
                .word_next (packed_next[gi*WORD_BITS +: WORD_BITS])
            );
        end
    endgenerate

    // arm_q resets high so an arm held through reset release is not an edge.
    assign arm_rise = arm & ~arm_q;

    always_comb begin
        state_d         = state_q;
        arm_d           = arm;
        bit_cnt_d       = bit_cnt_q;
        word_idx_d      = word_idx_q;
        words_written_d = words_written_q;
        addrb_d         = addrb_q;
        web_d           = 4'h0;
        dinb_d          = dinb_q;
        shift_en        = 1'b0;
        clr             = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arm_rise) begin
                    state_d         = ST_CAPTURE;
                    bit_cnt_d       = '0;
                    word_idx_d      = '0;
                    words_written_d = '0;
                    clr             = 1'b1;
                end
            end

            ST_CAPTURE: begin
                if (!arm) begin
                    // Abort wins over any sample this cycle; partial words are dropped.
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    clr       = 1'b1;
                end else if (mic_data_valid) begin
                    shift_en = 1'b1;
                    if (bit_cnt_q == BIT_CNT_W'(WORD_BITS - 1)) begin
                        bit_cnt_d       = '0;
                        web_d           = BYTE_EN_ALL;
                        addrb_d         = ADDR_WIDTH'({word_idx_q, 2'b00});
                        dinb_d          = packed_next;
                        word_idx_d      = word_idx_q + COUNT_WIDTH'(1);
                        words_written_d = words_written_q + (COUNT_WIDTH + 1)'(1);
                        if (word_idx_q == {COUNT_WIDTH{1'b1}}) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end

            ST_DONE: begin
                if (!arm) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            arm_q           <= 1'b1;
            bit_cnt_q       <= '0;
            word_idx_q      <= '0;
            words_written_q <= '0;
            addrb_q         <= '0;
            web_q           <= 4'h0;
            dinb_q          <= '0;
        end else begin
            state_q         <= state_d;
            arm_q           <= arm_d;
            bit_cnt_q       <= bit_cnt_d;
            word_idx_q      <= word_idx_d;
            words_written_q <= words_written_d;
            addrb_q         <= addrb_d;
            web_q           <= web_d;
            dinb_q          <= dinb_d;
        end
    end

    assign bram.addrb    = addrb_q;
    assign bram.web      = web_q;
    assign bram.dinb     = dinb_q;
    assign busy          = (state_q == ST_CAPTURE);
    assign done          = (state_q == ST_DONE);
    assign words_written = words_written_q;

endmodule

// File: tb/tb_pdm_capture_packer.sv
// Randomized bench for pdm_capture_packer: a bit-list reference model queues
// expected BRAM writes and a negedge monitor matches every web strobe against it.
module tb_pdm_capture_packer;
    import pdm_capture_pkg::*;

    localparam int NUM_MICS    = 8;
    localparam int COUNT_WIDTH = 2;
    localparam int ADDR_WIDTH  = 32;
    localparam int DEPTH       = 1 << COUNT_WIDTH;
    localparam int DATA_W      = 32 * NUM_MICS;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  arm;
    logic [NUM_MICS-1:0]   mic_data;
    logic                  mic_data_valid;
    logic                  busy;
    logic                  done;
    logic [COUNT_WIDTH:0]  words_written;

    pdm_capture_packer_if #(.NUM_MICS(NUM_MICS), .ADDR_WIDTH(ADDR_WIDTH)) bram_if ();

    pdm_capture_packer #(
        .NUM_MICS    (NUM_MICS),
        .COUNT_WIDTH (COUNT_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .arm            (arm),
        .mic_data       (mic_data),
        .mic_data_valid (mic_data_valid),
        .bram           (bram_if.master),
        .busy           (busy),
        .done           (done),
        .words_written  (words_written)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks = 0;
    int  n_fail   = 0;

    // Reference model: whether samples are being kept, bits gathered so far,
    // and how many words this capture has produced.
    bit          m_capturing = 0;
    int          m_bits      = 0;
    int          m_words     = 0;
    logic [31:0] m_acc [NUM_MICS];

    always @(negedge clk) begin
        if (bram_if.web !== 4'h0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got web=%h addrb=%0h, required no write", bram_if.web, bram_if.addrb);
            end else begin
                mon_e = exp_q.pop_front();
                if (bram_if.web !== BYTE_EN_ALL || bram_if.addrb !== mon_e.addr || bram_if.dinb !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL bram_write: got web=%h addrb=%0h dinb=%h, required web=%h addrb=%0h dinb=%h",
                             bram_if.web, bram_if.addrb, bram_if.dinb, BYTE_EN_ALL, mon_e.addr, mon_e.data);
                end else begin
                    $display("write addrb=%0h dinb[31:0]=%h ok", bram_if.addrb, bram_if.dinb[31:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end else begin
            $display("check %s = %0h ok", name, act);
        end
    endtask

    task automatic arm_rise();
        arm = 1'b0;
        step();
        arm = 1'b1;
        step();
        m_capturing = 1;
        m_bits      = 0;
        m_words     = 0;
        for (int k = 0; k < NUM_MICS; k++) m_acc[k] = '0;
    endtask

    task automatic drop_arm();
        arm = 1'b0;
        step();
        m_capturing = 0;
        m_bits      = 0;
    endtask

    task automatic send_valid(input logic [NUM_MICS-1:0] d, input int gap);
        wr_t w;
        mic_data       = d;
        mic_data_valid = 1'b1;
        if (m_capturing) begin
            for (int k = 0; k < NUM_MICS; k++) m_acc[k] = {m_acc[k][30:0], d[k]};
            m_bits++;
            if (m_bits == 32) begin
                w.addr = ADDR_WIDTH'(m_words * 4);
                for (int k = 0; k < NUM_MICS; k++) w.data[32*k +: 32] = m_acc[k];
                exp_q.push_back(w);
                m_bits = 0;
                m_words++;
                if (m_words == DEPTH) m_capturing = 0;
            end
        end
        step();
        mic_data_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic send_random(input int n);
        for (int i = 0; i < n; i++) send_valid(NUM_MICS'($urandom), int'($urandom_range(1, 3)));
    endtask

    initial begin
        logic [NUM_MICS-1:0] d;

        rst = 1'b1; arm = 1'b0; mic_data = '0; mic_data_valid = 1'b0;
        for (int k = 0; k < NUM_MICS; k++) m_acc[k] = '0;
        repeat (3) step();
        check("reset_addrb", DATA_W'(bram_if.addrb), 0);
        check("reset_web", DATA_W'(bram_if.web), 0);
        check("reset_dinb", bram_if.dinb, 0);
        check("reset_busy_done", DATA_W'({busy, done}), 0);
        check("reset_words_written", DATA_W'(words_written), 0);
        rst = 1'b0;
        step();

        // Alternating mic0 and constant-high mic7 give known first-word patterns.
        arm_rise();
        check("busy_after_arm", DATA_W'(busy), 1);
        for (int i = 0; i < 32; i++) begin
            d    = NUM_MICS'($urandom);
            d[0] = (i % 2 == 0);
            d[7] = 1'b1;
            send_valid(d, 1);
        end
        check("mic0_word", DATA_W'(bram_if.dinb[31:0]), 32'hAAAAAAAA);
        check("mic7_word", DATA_W'(bram_if.dinb[255:224]), 32'hFFFFFFFF);
        check("words_after_first", DATA_W'(words_written), 1);

        // Second word ends with a back-to-back valid landing on the strobe cycle.
        send_random(31);
        send_valid(NUM_MICS'($urandom), 0);
        send_valid(NUM_MICS'($urandom), 1);
        send_random(31);
        send_random(20);
        drop_arm();
        check("abort_busy", DATA_W'(busy), 0);
        check("abort_words_held", DATA_W'(words_written), 3);

        arm_rise();
        send_random(32);
        send_random(20);
        drop_arm();
        check("abort2_busy_done", DATA_W'({busy, done}), 0);
        check("abort2_words_held", DATA_W'(words_written), 1);

        // Fill the whole buffer, then confirm DONE ignores further samples.
        arm_rise();
        send_random(128);
        check("full_done", DATA_W'(done), 1);
        check("full_busy", DATA_W'(busy), 0);
        check("full_words", DATA_W'(words_written), DEPTH);
        check("full_last_addr", DATA_W'(bram_if.addrb), (DEPTH - 1) * 4);
        send_random(10);
        check("done_words_held", DATA_W'(words_written), DEPTH);
        drop_arm();
        check("idle_after_done", DATA_W'({busy, done}), 0);
        send_random(10);
        check("idle_words_held", DATA_W'(words_written), DEPTH);

        // Reset mid-capture with arm still high must not restart capture.
        arm_rise();
        send_random(40);
        rst = 1'b1;
        m_capturing = 0; m_bits = 0; m_words = 0;
        step();
        step();
        check("rst_addrb", DATA_W'(bram_if.addrb), 0);
        check("rst_dinb", bram_if.dinb, 0);
        check("rst_web_busy_done", DATA_W'({bram_if.web, busy, done}), 0);
        check("rst_words", DATA_W'(words_written), 0);
        rst = 1'b0;
        step();
        send_random(40);
        check("no_capture_arm_held", DATA_W'({busy, words_written}), 0);
        arm_rise();
        send_random(32);
        check("restart_words", DATA_W'(words_written), 1);
        drop_arm();
        repeat (3) step();

        check("scoreboard_drained", DATA_W'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
